// File: rtl/axis_dac_packer_pkg.sv
// Shared constants, the per-sample result type and arithmetic helpers for the DAC packer.
package axis_dac_packer_pkg;

  localparam int DAC_WIDTH = 14;
  localparam int DAC_MAX   = 8191;
  localparam int DAC_MIN   = -8192;
  localparam int IN_WIDTH  = 24;
  localparam int CNT_WIDTH = 16;
  localparam int EXT_WIDTH = IN_WIDTH + 1;

  // One scaled DAC code plus a flag telling whether it had to be clamped.
  typedef struct packed {
    logic                 sat;
    logic [DAC_WIDTH-1:0] value;
  } dac_sample_t;

  // Round-half-up right shift of a signed 24-bit sample, then clamp to the 14-bit DAC range.
  function automatic dac_sample_t scale_sample(input logic [IN_WIDTH-1:0] raw, input int shift);
    logic signed [EXT_WIDTH-1:0] ext;
    logic signed [EXT_WIDTH-1:0] shifted;
    dac_sample_t                 res;
    ext     = {raw[IN_WIDTH-1], raw} + (EXT_WIDTH'(1) << (shift - 1));
    shifted = ext >>> shift;
    if (int'(shifted) > DAC_MAX) begin
      res.sat   = 1'b1;
      res.value = DAC_WIDTH'(DAC_MAX);
    end else if (int'(shifted) < DAC_MIN) begin
      res.sat   = 1'b1;
      res.value = DAC_WIDTH'(DAC_MIN);
    end else begin
      res.sat   = 1'b0;
      res.value = shifted[DAC_WIDTH-1:0];
    end
    return res;
  endfunction

  // Status counters stick at all-ones instead of wrapping back to zero.
  function automatic logic [CNT_WIDTH-1:0] cnt_inc(input logic [CNT_WIDTH-1:0] c);
    return (c == '1) ? c : c + CNT_WIDTH'(1);
  endfunction

endpackage

// File: rtl/axis_sample_fifo.sv
// Single-clock sample FIFO with registered write-ready and empty flags and a show-ahead read port.
module axis_sample_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic             aclk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_ready,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_next;
  logic             do_wr;
  logic             do_rd;

  assign do_wr   = wr_en && wr_ready;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // Occupancy after this cycle's write and read; the flags are derived from it so they stay registered.
  always_comb begin
    count_next = count + CW'(do_wr) - CW'(do_rd);
  end

  // Storage array; contents are don't-care until the pointers say otherwise, so no reset here.
  always_ff @(posedge aclk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two; ready stays low while reset is held.
  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      empty    <= 1'b1;
      wr_ready <= 1'b0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count    <= count_next;
      empty    <= (count_next == '0);
      wr_ready <= (count_next != CW'(DEPTH));
    end
  end

endmodule

// File: rtl/axis_dac_packer.sv
// Pairs I and Q AXI-Stream samples, scales them to 14-bit DAC codes and packs them into one 32-bit word.
module axis_dac_packer #(
  parameter int SHIFT      = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        aclk,
  input  logic        reset,
  input  logic [31:0] s_axis_i_tdata,
  input  logic        s_axis_i_tvalid,
  output logic        s_axis_i_tready,
  input  logic [31:0] s_axis_q_tdata,
  input  logic        s_axis_q_tvalid,
  output logic        s_axis_q_tready,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  input  logic        clr,
  output logic [15:0] sat_i_cnt,
  output logic [15:0] sat_q_cnt,
  output logic [15:0] underrun_cnt
);

  import axis_dac_packer_pkg::*;

  logic [IN_WIDTH-1:0] fifo_i_data;
  logic [IN_WIDTH-1:0] fifo_q_data;
  logic                fifo_i_empty;
  logic                fifo_q_empty;
  logic                pop;
  logic                out_xfer;
  logic                underrun_event;
  logic                underrun_armed;
  dac_sample_t         i_scaled;
  dac_sample_t         q_scaled;
  logic                unused_upper;

  assign unused_upper = ^{s_axis_i_tdata[31:IN_WIDTH], s_axis_q_tdata[31:IN_WIDTH]};

  axis_sample_fifo #(
    .WIDTH (IN_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo_i (
    .aclk     (aclk),
    .reset    (reset),
    .wr_en    (s_axis_i_tvalid),
    .wr_data  (s_axis_i_tdata[IN_WIDTH-1:0]),
    .wr_ready (s_axis_i_tready),
    .rd_en    (pop),
    .rd_data  (fifo_i_data),
    .empty    (fifo_i_empty)
  );

  axis_sample_fifo #(
    .WIDTH (IN_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo_q (
    .aclk     (aclk),
    .reset    (reset),
    .wr_en    (s_axis_q_tvalid),
    .wr_data  (s_axis_q_tdata[IN_WIDTH-1:0]),
    .wr_ready (s_axis_q_tready),
    .rd_en    (pop),
    .rd_data  (fifo_q_data),
    .empty    (fifo_q_empty)
  );

  // A pair leaves both FIFOs together only when the output register is free or being drained.
  assign pop            = !fifo_i_empty && !fifo_q_empty && (!m_axis_tvalid || m_axis_tready);
  assign out_xfer       = m_axis_tvalid && m_axis_tready;
  assign underrun_event = underrun_armed && m_axis_tready && !m_axis_tvalid;
  assign i_scaled       = scale_sample(fifo_i_data, SHIFT);
  assign q_scaled       = scale_sample(fifo_q_data, SHIFT);

  // Output register: loads on pop, otherwise holds until the consumer takes the word.
  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
    end else if (pop) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= {2'b00, i_scaled.value, 2'b00, q_scaled.value};
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

  // I-channel clamp counter; clr beats a same-cycle increment.
  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      sat_i_cnt <= '0;
    end else if (clr) begin
      sat_i_cnt <= '0;
    end else if (pop && i_scaled.sat) begin
      sat_i_cnt <= cnt_inc(sat_i_cnt);
    end
  end

  // Q-channel clamp counter; clr beats a same-cycle increment.
  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      sat_q_cnt <= '0;
    end else if (clr) begin
      sat_q_cnt <= '0;
    end else if (pop && q_scaled.sat) begin
      sat_q_cnt <= cnt_inc(sat_q_cnt);
    end
  end

  // Underrun tracking starts at the first delivered word so start-up latency is not counted.
  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      underrun_armed <= 1'b0;
      underrun_cnt   <= '0;
    end else if (clr) begin
      underrun_armed <= 1'b0;
      underrun_cnt   <= '0;
    end else begin
      if (out_xfer) begin
        underrun_armed <= 1'b1;
      end
      if (underrun_event) begin
        underrun_cnt <= cnt_inc(underrun_cnt);
      end
    end
  end

endmodule

// File: tb/tb_axis_dac_packer.sv
// Testbench for axis_dac_packer: vector table, scoreboard monitor and hand-written corner sequences.
module tb_axis_dac_packer;

  localparam int SHIFT      = 10;
  localparam int FIFO_DEPTH = 4;
  localparam int TIMEOUT    = 300;
  localparam int NVEC       = 8;
  localparam int NSTREAM    = 100;

  logic        aclk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] s_axis_i_tdata = '0;
  logic        s_axis_i_tvalid = 1'b0;
  logic        s_axis_i_tready;
  logic [31:0] s_axis_q_tdata = '0;
  logic        s_axis_q_tvalid = 1'b0;
  logic        s_axis_q_tready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic        clr = 1'b0;
  logic [15:0] sat_i_cnt;
  logic [15:0] sat_q_cnt;
  logic [15:0] underrun_cnt;

  int          asserts = 0;
  int          failures = 0;
  int          out_count = 0;
  int          i_acc = 0;
  int          cycle = 0;
  logic [31:0] last_tdata = '0;
  logic [13:0] exp_i[$];
  logic [13:0] exp_q[$];
  logic [13:0] ei;
  logic [13:0] eq;

  typedef struct {
    logic [31:0] i_data;
    logic [31:0] q_data;
    logic [31:0] exp_tdata;
    int          sat_i;
    int          sat_q;
  } vec_t;

  vec_t        vecs[NVEC];
  logic [31:0] rnd_i[NSTREAM];
  logic [31:0] rnd_q[NSTREAM];

  axis_dac_packer #(
    .SHIFT      (SHIFT),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .aclk            (aclk),
    .reset           (reset),
    .s_axis_i_tdata  (s_axis_i_tdata),
    .s_axis_i_tvalid (s_axis_i_tvalid),
    .s_axis_i_tready (s_axis_i_tready),
    .s_axis_q_tdata  (s_axis_q_tdata),
    .s_axis_q_tvalid (s_axis_q_tvalid),
    .s_axis_q_tready (s_axis_q_tready),
    .m_axis_tdata    (m_axis_tdata),
    .m_axis_tvalid   (m_axis_tvalid),
    .m_axis_tready   (m_axis_tready),
    .clr             (clr),
    .sat_i_cnt       (sat_i_cnt),
    .sat_q_cnt       (sat_q_cnt),
    .underrun_cnt    (underrun_cnt)
  );

  always #5 aclk = ~aclk;

  // Reference arithmetic: signed 24-bit input, round half up, shift, clamp to 14 bits.
  function automatic logic [13:0] model(input logic [31:0] d);
    logic signed [23:0] s;
    int                 v;
    s = d[23:0];
    v = s;
    v = (v + (1 << (SHIFT - 1))) >>> SHIFT;
    if (v > 8191) v = 8191;
    else if (v < -8192) v = -8192;
    return v[13:0];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    asserts++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic timeoutFail(input string name);
    asserts++;
    failures++;
    $display("[TB] FAIL %s: timed out after %0d cycles", name, TIMEOUT);
  endtask

  task automatic send_i(input logic [31:0] d);
    int n = 0;
    s_axis_i_tdata  = d;
    s_axis_i_tvalid = 1'b1;
    @(negedge aclk);
    while (!s_axis_i_tready && n < TIMEOUT) begin
      @(negedge aclk);
      n++;
    end
    if (!s_axis_i_tready) timeoutFail("send_i");
    @(posedge aclk);
    #1;
  endtask

  task automatic send_q(input logic [31:0] d);
    int n = 0;
    s_axis_q_tdata  = d;
    s_axis_q_tvalid = 1'b1;
    @(negedge aclk);
    while (!s_axis_q_tready && n < TIMEOUT) begin
      @(negedge aclk);
      n++;
    end
    if (!s_axis_q_tready) timeoutFail("send_q");
    @(posedge aclk);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] i_d, input logic [31:0] q_d);
    fork
      send_i(i_d);
      send_q(q_d);
    join
    s_axis_i_tvalid = 1'b0;
    s_axis_q_tvalid = 1'b0;
  endtask

  task automatic wait_out(input int target, input string name);
    int n = 0;
    while (out_count < target && n < TIMEOUT) begin
      @(posedge aclk);
      n++;
    end
    if (out_count < target) timeoutFail(name);
    #1;
  endtask

  task automatic clrPulse();
    clr = 1'b1;
    @(posedge aclk);
    #1;
    clr = 1'b0;
  endtask

  // Scoreboard monitor: records accepted samples and checks each delivered word, sampled mid-cycle.
  always @(negedge aclk) begin
    if (reset) begin
      exp_i.delete();
      exp_q.delete();
    end else begin
      cycle++;
      if (s_axis_i_tvalid && s_axis_i_tready) begin
        exp_i.push_back(model(s_axis_i_tdata));
        i_acc++;
      end
      if (s_axis_q_tvalid && s_axis_q_tready) begin
        exp_q.push_back(model(s_axis_q_tdata));
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_i.size() == 0 || exp_q.size() == 0) begin
          checkOutput("unexpected output", m_axis_tdata, 32'hFFFF_FFFF);
        end else begin
          ei = exp_i.pop_front();
          eq = exp_q.pop_front();
          checkOutput("scoreboard tdata", m_axis_tdata, {2'b00, ei, 2'b00, eq});
        end
        last_tdata = m_axis_tdata;
        out_count++;
      end
    end
  end

  initial begin
    int base;
    int base_i;
    int c0;
    int c1;
    int exp_sat_i;
    int exp_sat_q;

    vecs[0] = '{32'h0000_0400, 32'h00FF_FC00, 32'h0001_3FFF, 0, 0};
    vecs[1] = '{32'h007F_FFFF, 32'h0080_0000, 32'h1FFF_2000, 1, 0};
    vecs[2] = '{32'h0000_01FF, 32'h0000_0200, 32'h0000_0001, 0, 0};
    vecs[3] = '{32'h00FF_FE00, 32'h0000_0000, 32'h0000_0000, 0, 0};
    vecs[4] = '{32'h0080_0000, 32'h007F_FFFF, 32'h2000_1FFF, 0, 1};
    vecs[5] = '{32'hAB00_0400, 32'hFFF0_0000, 32'h0001_3C00, 0, 0};
    vecs[6] = '{32'h001F_FE00, 32'h00E0_0000, 32'h0800_3800, 0, 0};
    vecs[7] = '{32'h003F_FFFF, 32'h00C0_0000, 32'h1000_3000, 0, 0};
    for (int k = 0; k < NSTREAM; k++) begin
      rnd_i[k] = $urandom;
      rnd_q[k] = $urandom;
    end

    // Reset values while reset is held, then ready on the first edge after release.
    #1 reset = 1'b1;
    #2;
    checkOutput("reset tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    checkOutput("reset tdata", m_axis_tdata, 32'd0);
    checkOutput("reset i_tready", {31'd0, s_axis_i_tready}, 32'd0);
    checkOutput("reset q_tready", {31'd0, s_axis_q_tready}, 32'd0);
    checkOutput("reset counters", {sat_i_cnt, sat_q_cnt}, 32'd0);
    checkOutput("reset underrun", {16'd0, underrun_cnt}, 32'd0);
    repeat (3) @(posedge aclk);
    #1 reset = 1'b0;
    checkOutput("tready before edge", {31'd0, s_axis_i_tready}, 32'd0);
    @(posedge aclk);
    #1;
    checkOutput("tready after edge", {30'd0, s_axis_i_tready, s_axis_q_tready}, 32'd3);

    // Vector table: arithmetic, rounding, saturation and one-edge output latency.
    exp_sat_i = 0;
    exp_sat_q = 0;
    for (int r = 0; r < NVEC; r++) begin
      base = out_count;
      applyStimulus(vecs[r].i_data, vecs[r].q_data);
      checkOutput($sformatf("row%0d tvalid early", r), {31'd0, m_axis_tvalid}, 32'd0);
      @(posedge aclk);
      #1;
      checkOutput($sformatf("row%0d tvalid latency", r), {31'd0, m_axis_tvalid}, 32'd1);
      wait_out(base + 1, $sformatf("row%0d output", r));
      exp_sat_i += vecs[r].sat_i;
      exp_sat_q += vecs[r].sat_q;
      checkOutput($sformatf("row%0d tdata", r), last_tdata, vecs[r].exp_tdata);
      checkOutput($sformatf("row%0d sat_i", r), {16'd0, sat_i_cnt}, 32'(exp_sat_i));
      checkOutput($sformatf("row%0d sat_q", r), {16'd0, sat_q_cnt}, 32'(exp_sat_q));
    end
    clrPulse();
    checkOutput("clr sat counters", {sat_i_cnt, sat_q_cnt}, 32'd0);

    // I streams alone: its FIFO fills, Q keeps accepting, nothing comes out until Q catches up.
    base   = out_count;
    base_i = i_acc;
    fork
      begin
        for (int k = 0; k < 6; k++) send_i(32'((k + 1) * 1024));
        s_axis_i_tvalid = 1'b0;
      end
      begin
        repeat (10) @(posedge aclk);
        #1;
        checkOutput("i fifo fill count", 32'(i_acc - base_i), 32'd4);
        checkOutput("i tready low when full", {31'd0, s_axis_i_tready}, 32'd0);
        checkOutput("q tready independent", {31'd0, s_axis_q_tready}, 32'd1);
        checkOutput("no output without q", 32'(out_count - base), 32'd0);
        for (int k = 0; k < 6; k++) send_q(32'((k + 1) * 2048));
        s_axis_q_tvalid = 1'b0;
      end
    join
    wait_out(base + 6, "paired outputs");
    checkOutput("paired output count", 32'(out_count - base), 32'd6);

    // Output held with tready low must keep valid and data stable.
    m_axis_tready = 1'b0;
    base = out_count;
    applyStimulus(32'h0000_0400, 32'h00FF_FC00);
    @(posedge aclk);
    #1;
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("hold tvalid %0d", k), {31'd0, m_axis_tvalid}, 32'd1);
      checkOutput($sformatf("hold tdata %0d", k), m_axis_tdata, 32'h0001_3FFF);
      @(posedge aclk);
      #1;
    end
    m_axis_tready = 1'b1;
    wait_out(base + 1, "hold release");

    // Back-to-back stream must deliver one word per cycle with no underruns.
    clrPulse();
    base = out_count;
    c0   = 0;
    c1   = 0;
    fork
      begin
        for (int k = 0; k < NSTREAM; k++) begin
          fork
            send_i(rnd_i[k]);
            send_q(rnd_q[k]);
          join
        end
        s_axis_i_tvalid = 1'b0;
        s_axis_q_tvalid = 1'b0;
      end
      begin
        wait_out(base + 1, "stream first");
        c0 = cycle;
        wait_out(base + NSTREAM, "stream last");
        c1 = cycle;
      end
    join
    checkOutput("stream underrun", {16'd0, underrun_cnt}, 32'd0);
    checkOutput("stream count", 32'(out_count - base), 32'(NSTREAM));
    checkOutput("stream throughput", 32'(c1 - c0), 32'(NSTREAM - 1));

    // Underrun counting after the first transfer, clr priority and disarm.
    clrPulse();
    base = out_count;
    applyStimulus(32'h0000_0800, 32'h0000_0C00);
    wait_out(base + 1, "underrun arm");
    repeat (5) @(posedge aclk);
    #1;
    checkOutput("underrun count", {16'd0, underrun_cnt}, 32'd5);
    clrPulse();
    checkOutput("underrun clr", {16'd0, underrun_cnt}, 32'd0);
    repeat (3) @(posedge aclk);
    #1;
    checkOutput("underrun disarmed", {16'd0, underrun_cnt}, 32'd0);

    // Reset in the middle of buffered traffic drops everything at once.
    m_axis_tready = 1'b0;
    for (int k = 0; k < 3; k++) applyStimulus(32'((k + 3) * 1024), 32'((k + 5) * 1024));
    @(posedge aclk);
    #2 reset = 1'b1;
    #1;
    checkOutput("midreset tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    checkOutput("midreset tdata", m_axis_tdata, 32'd0);
    checkOutput("midreset tready", {30'd0, s_axis_i_tready, s_axis_q_tready}, 32'd0);
    repeat (2) @(posedge aclk);
    #1 reset = 1'b0;
    m_axis_tready = 1'b1;
    base = out_count;
    repeat (6) @(posedge aclk);
    #1;
    checkOutput("flushed after reset", 32'(out_count - base), 32'd0);
    applyStimulus(32'h007F_FFFF, 32'h0000_0400);
    wait_out(base + 1, "post reset output");
    checkOutput("post reset tdata", last_tdata, 32'h1FFF_0001);
    checkOutput("post reset sat_i", {16'd0, sat_i_cnt}, 32'd1);

    repeat (2) @(posedge aclk);
    #1;
    checkOutput("scoreboard drain i", 32'(exp_i.size()), 32'd0);
    checkOutput("scoreboard drain q", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
